// File: rtl/uart_tx_arbiter_pkg.sv
// ============================================================================
// uart_arb_pkg: shared state encoding and constants for uart_tx_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_t;

   localparam int ARB_BUSY_TIMEOUT = 4;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// uart_tx_arbiter_if: requester handshake and transmitter bus of the arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if #(
   parameter int N_REQ      = 4,
   parameter int DATA_N_BIT = 6
);
   localparam int ID_W = uart_arb_pkg::idx_width(N_REQ);

   logic [N_REQ*DATA_N_BIT-1:0] req_din;
   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0]            req_ack;
   logic [DATA_N_BIT-1:0]       tx_din;
   logic                        tx_din_valid;
   logic                        tx_ready;
   logic [ID_W-1:0]             grant_id;
   logic                        busy;

   modport master (
      output req_din, req_valid, tx_ready,
      input  req_ack, tx_din, tx_din_valid, grant_id, busy
   );

   modport slave (
      input  req_din, req_valid, tx_ready,
      output req_ack, tx_din, tx_din_valid, grant_id, busy
   );

endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// ============================================================================
// rr_arbiter: combinational round-robin (or fixed-priority when
// UART_ARB_FIXED_PRIO_EN is defined) winner select. Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  wire logic [N_REQ-1:0]             req,
   input  wire logic [idx_width(N_REQ)-1:0]  ptr,
   output logic      [N_REQ-1:0]             gnt,
   output logic      [idx_width(N_REQ)-1:0]  gnt_idx
);
   localparam int ID_W = idx_width(N_REQ);

   logic            w_found;
   logic [ID_W-1:0] w_cand;
   int              w_sum;

`ifdef UART_ARB_FIXED_PRIO_EN
   logic w_unused_ptr;
   assign w_unused_ptr = ^ptr;
`endif

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      w_found = 1'b0;
      w_cand  = '0;
      w_sum   = 0;
      for (int k = 0; k < N_REQ; k++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
         w_sum = k;
`else
         w_sum = int'(ptr) + k;
         if (w_sum >= N_REQ) begin
            w_sum = w_sum - N_REQ;
         end
`endif
         w_cand = w_sum[ID_W-1:0];
         if (!w_found && req[w_cand]) begin
            w_found      = 1'b1;
            gnt[w_cand]  = 1'b1;
            gnt_idx      = w_cand;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter: shares one simple_uart_tx among N_REQ requesters, one frame
// at a time. Define UART_ARB_FIXED_PRIO_EN for fixed priority. Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int DATA_N_BIT = 6
) (
   input wire logic          clk,
   input wire logic          async_rst_n,
   uart_tx_arbiter_if.slave  bus
);
   localparam int ID_W  = idx_width(N_REQ);
   localparam int CNT_W = $clog2(ARB_BUSY_TIMEOUT + 1);

   arb_state_t            r_state;
   arb_state_t            w_state_nxt;
   logic [CNT_W-1:0]      r_wb_cnt;
   logic [CNT_W-1:0]      w_wb_cnt_nxt;
   logic [N_REQ-1:0]      w_gnt;
   logic [N_REQ-1:0]      w_ack_nxt;
   logic [N_REQ-1:0]      r_ack;
   logic [ID_W-1:0]       w_gnt_idx;
   logic [ID_W-1:0]       w_ptr;
   logic [ID_W-1:0]       r_grant_id;
   logic [DATA_N_BIT-1:0] r_tx_din;
   logic [DATA_N_BIT-1:0] w_win_word;
   logic                  r_tx_din_valid;
   logic                  w_tx_din_valid_nxt;
   logic                  r_busy;
   logic                  w_load;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr_arbiter (
      .req     (bus.req_valid),
      .ptr     (w_ptr),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx)
   );

   assign w_win_word = bus.req_din[w_gnt_idx*DATA_N_BIT +: DATA_N_BIT];

`ifdef UART_ARB_FIXED_PRIO_EN
   assign w_ptr = '0;
`else
   logic [ID_W-1:0] r_ptr;

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         r_ptr <= '0;
      end else if (w_load) begin
         if (w_gnt_idx == ID_W'(N_REQ - 1)) begin
            r_ptr <= '0;
         end else begin
            r_ptr <= w_gnt_idx + 1'b1;
         end
      end
   end

   assign w_ptr = r_ptr;
`endif

   always_comb begin
      w_state_nxt        = r_state;
      w_wb_cnt_nxt       = r_wb_cnt;
      w_ack_nxt          = '0;
      w_tx_din_valid_nxt = 1'b0;
      w_load             = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.tx_ready && (|bus.req_valid)) begin
               w_load      = 1'b1;
               w_ack_nxt   = w_gnt;
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            w_tx_din_valid_nxt = 1'b1;
            w_wb_cnt_nxt       = '0;
            w_state_nxt        = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // A transmitter that never leaves ready dropped the strobe; give up.
            if (!bus.tx_ready) begin
               w_state_nxt = WAIT_DONE;
            end else if (r_wb_cnt == CNT_W'(ARB_BUSY_TIMEOUT - 1)) begin
               w_state_nxt = IDLE;
            end else begin
               w_wb_cnt_nxt = r_wb_cnt + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (bus.tx_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         r_state        <= IDLE;
         r_wb_cnt       <= '0;
         r_ack          <= '0;
         r_tx_din       <= '0;
         r_tx_din_valid <= 1'b0;
         r_grant_id     <= '0;
         r_busy         <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_wb_cnt       <= w_wb_cnt_nxt;
         r_ack          <= w_ack_nxt;
         r_tx_din_valid <= w_tx_din_valid_nxt;
         r_busy         <= (w_state_nxt != IDLE);
         if (w_load) begin
            r_tx_din   <= w_win_word;
            r_grant_id <= w_gnt_idx;
         end
      end
   end

   assign bus.req_ack      = r_ack;
   assign bus.tx_din       = r_tx_din;
   assign bus.tx_din_valid = r_tx_din_valid;
   assign bus.grant_id     = r_grant_id;
   assign bus.busy         = r_busy;

endmodule

`default_nettype wire
